// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared 128-bit block memory to the I-cache or the D-cache, one transaction at a time.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_i_vld;
  logic w_d_vld;
  logic w_d_wins_tie;
  logic w_grant_i;
  logic w_grant_d;

  // Read and write together is malformed and never granted.
  assign w_i_vld = i_read ^ i_write;
  assign w_d_vld = d_read ^ d_write;

`ifdef ARB_RR_EN
  logic r_last_d;

  assign w_d_wins_tie = ~r_last_d;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  assign w_d_wins_tie = 1'b1;
`endif

  assign w_grant_d = (r_state == IDLE) && w_d_vld && (!w_i_vld || w_d_wins_tie);
  assign w_grant_i = (r_state == IDLE) && w_i_vld && !w_grant_d;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = SERVE_D;
        end else if (w_grant_i) begin
          w_state_nxt = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    arb_busy = 1'b0;
    case (r_state)
      SERVE_I: begin
        i_ready  = mem_ready;
        arb_busy = 1'b1;
      end
      SERVE_D: begin
        d_ready  = mem_ready;
        arb_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and write data stay put after completion; only the strobes drop.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (w_grant_d) begin
      mem_read  <= d_read;
      mem_write <= d_write;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (w_grant_i) begin
      mem_read  <= i_read;
      mem_write <= i_write;
      mem_addr  <= i_addr;
      mem_wdata <= i_wdata;
    end else if (r_state == IDLE || mem_ready) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checked every cycle plus directed literal checks.
// Honours ARB_RR_EN in the same way as the design build.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int C_NONE = 0;
  localparam int C_I    = 1;
  localparam int C_D    = 2;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          arb_busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns memory and which transaction it was given.
  int            m_owner;
  int            m_pick;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
`ifdef ARB_RR_EN
  logic          m_last_d;
`endif

  function automatic int pick(input logic iv, input logic dv);
    if (iv && dv) begin
`ifdef ARB_RR_EN
      return m_last_d ? C_I : C_D;
`else
      return C_D;
`endif
    end
    if (dv) return C_D;
    if (iv) return C_I;
    return C_NONE;
  endfunction

  always_comb m_pick = pick(i_read ^ i_write, d_read ^ d_write);

  always @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      m_owner <= C_NONE;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
`ifdef ARB_RR_EN
      m_last_d <= 1'b0;
`endif
    end else if (m_owner == C_NONE) begin
      m_owner <= m_pick;
      if (m_pick == C_D) begin
        m_rd <= d_read; m_wr <= d_write; m_addr <= d_addr; m_wdata <= d_wdata;
      end else if (m_pick == C_I) begin
        m_rd <= i_read; m_wr <= i_write; m_addr <= i_addr; m_wdata <= i_wdata;
      end else begin
        m_rd <= 1'b0; m_wr <= 1'b0;
      end
`ifdef ARB_RR_EN
      if (m_pick != C_NONE) m_last_d <= (m_pick == C_D);
`endif
    end else if (mem_ready) begin
      m_owner <= C_NONE;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("mem_read",  {127'd0, mem_read},  {127'd0, m_rd});
    chk("mem_write", {127'd0, mem_write}, {127'd0, m_wr});
    chk("mem_addr",  {100'd0, mem_addr},  {100'd0, m_addr});
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("arb_busy",  {127'd0, arb_busy},  {127'd0, (m_owner != C_NONE)});
    chk("i_ready",   {127'd0, i_ready},   {127'd0, (m_owner == C_I && mem_ready)});
    chk("d_ready",   {127'd0, d_ready},   {127'd0, (m_owner == C_D && mem_ready)});
    if (m_owner == C_I && mem_ready) chk("i_rdata", i_rdata, mem_rdata);
    if (m_owner == C_D && mem_ready) chk("d_rdata", d_rdata, mem_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    @(negedge clk);
    chk(name, act, exp);
  endtask

  // Tie between I (0x100) and D (0x200); both hold their request until served.
  task automatic tie(input logic exp_d_first, input string tag);
    i_read = 1'b1; d_read = 1'b1; i_addr = 28'h100; d_addr = 28'h200;
    step();
    @(negedge clk);
    chk({tag, "_first_addr"}, {100'd0, mem_addr}, exp_d_first ? 128'h200 : 128'h100);
    step();
    mem_ready = 1'b1; mem_rdata = {4{32'h1111_0000}};
    @(negedge clk);
    chk({tag, "_first_rdy"}, {126'd0, d_ready, i_ready}, exp_d_first ? 128'h2 : 128'h1);
    step();
    mem_ready = 1'b0;
    if (exp_d_first) d_read = 1'b0; else i_read = 1'b0;
    lit({tag, "_gap_busy"}, {127'd0, arb_busy}, 128'h0);
    step();
    @(negedge clk);
    chk({tag, "_second_addr"}, {100'd0, mem_addr}, exp_d_first ? 128'h100 : 128'h200);
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; i_read = 1'b0; d_read = 1'b0;
  endtask

`ifdef ARB_RR_EN
  localparam logic TIE2_D_FIRST = 1'b0;
`else
  localparam logic TIE2_D_FIRST = 1'b1;
`endif

  initial begin
    proc_reset = 1'b1;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) step();
    lit("rst_busy", {127'd0, arb_busy}, 128'h0);
    lit("rst_addr", {100'd0, mem_addr}, 128'h0);
    proc_reset = 1'b0;
    step();

    // Single I read with latency and ready routing
    i_read = 1'b1; i_addr = 28'h0000010;
    step();
    lit("t1_mem_read", {127'd0, mem_read}, 128'h1);
    chk("t1_mem_addr", {100'd0, mem_addr}, 128'h10);
    step();
    mem_ready = 1'b1; mem_rdata = {16{8'hA5}};
    @(negedge clk);
    chk("t1_i_ready", {127'd0, i_ready}, 128'h1);
    chk("t1_i_rdata", i_rdata, {16{8'hA5}});
    chk("t1_d_ready", {127'd0, d_ready}, 128'h0);
    step();
    mem_ready = 1'b0; i_read = 1'b0;
    lit("t1_read_drop", {127'd0, mem_read}, 128'h0);
    step();

    // Tie 1 (last grant I): D first in both builds
    tie(1'b1, "tie1");
    step();

    // D write-back then refill
    d_write = 1'b1; d_addr = 28'h3; d_wdata = {4{32'hDEAD_BEEF}};
    step();
    lit("wb_mem_write", {126'd0, mem_write, mem_read}, 128'h2);
    chk("wb_addr", {100'd0, mem_addr}, 128'h3);
    chk("wb_wdata", mem_wdata, {4{32'hDEAD_BEEF}});
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; d_write = 1'b0; d_read = 1'b1; d_addr = 28'h7;
    lit("wb_gap", {126'd0, mem_write, mem_read}, 128'h0);
    step();
    lit("rf_mem_read", {126'd0, mem_write, mem_read}, 128'h1);
    chk("rf_addr", {100'd0, mem_addr}, 128'h7);
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; d_read = 1'b0;
    step();

    // Tie 2 (last grant D): round-robin picks I first, fixed priority picks D
    tie(TIE2_D_FIRST, "tie2");
    step();

    // Malformed request and stray mem_ready in IDLE
    d_read = 1'b1; d_write = 1'b1;
    repeat (2) step();
    lit("bad_busy", {127'd0, arb_busy}, 128'h0);
    mem_ready = 1'b1;
    step();
    lit("stray_ready", {126'd0, d_ready, i_ready}, 128'h0);
    mem_ready = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step();

    // Client withdraws mid-service; latched transaction still completes
    i_read = 1'b1; i_addr = 28'h20;
    step();
    i_read = 1'b0; i_addr = 28'h99;
    step();
    mem_ready = 1'b1; mem_rdata = {8{16'h5A5A}};
    lit("wd_addr_held", {100'd0, mem_addr}, 128'h20);
    chk("wd_i_ready", {127'd0, i_ready}, 128'h1);
    step();
    mem_ready = 1'b0;
    step();

    // Reset between edges during SERVE_I, then re-grant of pending read
    i_read = 1'b1; i_addr = 28'h55;
    step();
    lit("rs_pre", {127'd0, mem_read}, 128'h1);
    #2 proc_reset = 1'b1;
    #1;
    chk("rs_mem_read", {127'd0, mem_read}, 128'h0);
    chk("rs_busy", {127'd0, arb_busy}, 128'h0);
    step();
    proc_reset = 1'b0;
    step();
    lit("rs_regrant", {127'd0, mem_read}, 128'h1);
    chk("rs_addr", {100'd0, mem_addr}, 128'h55);
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; i_read = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-client arbiter between the instruction-cache and data-cache memory interfaces and the single shared 128-bit block memory. Each cache talks to it exactly as it would to memory: level request, one-cycle ready pulse, 28-bit block address. The arbiter grants one client at a time, registers that client's request, drives memory, and routes the ready pulse back only to the granted client.

Parameters:
ADDR_W, 28, block address width (word address minus the 2 word-offset bits)
DATA_W, 128, block data width (4 words)

Ports:
clk  in  1  system clock, rising edge
proc_reset  in  1  asynchronous, active-high reset
i_read  in  1  I-cache block read request (level, held until i_ready)
i_write  in  1  I-cache block write request (level)
i_addr  in  ADDR_W  I-cache block address
i_wdata  in  DATA_W  I-cache write block
i_rdata  out  DATA_W  read block to I-cache
i_ready  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache block read request
d_write  in  1  D-cache block write request
d_addr  in  ADDR_W  D-cache block address
d_wdata  in  DATA_W  D-cache write block
d_rdata  out  DATA_W  read block to D-cache
d_ready  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  memory read request (registered)
mem_write  out  1  memory write request (registered)
mem_addr  out  ADDR_W  memory block address (registered)
mem_wdata  out  DATA_W  memory write block (registered)
mem_rdata  in  DATA_W  memory read block
mem_ready  in  1  memory completion pulse
arb_busy  out  1  high while a transaction is outstanding (state != IDLE)

Behaviour:
- Reset (async, immediate): state=IDLE; mem_read=mem_write=0; mem_addr=0; mem_wdata=0; last-grant=I; i_ready=d_ready=0; arb_busy=0.
- Client request valid = read XOR write. Read and write both high is treated as no request and is never granted.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: if exactly one client is valid, grant it; if both are valid, apply priority (default D over I). On the grant edge, latch the client's read/write/addr/wdata into the mem_* registers and move to SERVE_x. No valid request: stay in IDLE with mem_read=mem_write=0.
- Latency: a request seen in IDLE at cycle N appears on mem_* at cycle N+1.
- SERVE_x: hold mem_* stable. Pass mem_ready combinationally to x_ready only; the other client's ready is 0. On mem_ready, return to IDLE next edge, and mem_read/mem_write drop to 0 at that edge.
- i_rdata and d_rdata are both driven directly from mem_rdata. Only the matching ready qualifies them.
- Back-to-back: after the completing cycle, arbitration resumes in IDLE on the following cycle. This serves a cache that moves from write-back straight to refill: one IDLE cycle, then re-grant.
- Client changes or drops its request while being served: ignored. The latched transaction completes and the ready pulse is still delivered.
- mem_ready while in IDLE: ignored; no ready is routed.
- Reset mid-transaction: the memory request is abandoned immediately and the arbiter sits in IDLE.

Optional Feature:
ARB_RR_EN: when defined, a simultaneous I and D request is resolved round-robin. The client not granted last time wins, and last-grant updates on every grant. When undefined, D always wins a tie and last-grant is unused.

Test Plan:
- Reset, then i_read=1, i_addr=28'h0000010 → mem_read=1, mem_addr=28'h0000010 one cycle later. mem_ready with mem_rdata=128'hA5..A5 → i_ready=1 in the same cycle, i_rdata=A5..A5, d_ready=0. mem_read=0 the next cycle.
- i_read and d_read asserted in the same cycle, macro off → D served first (mem_addr=d_addr), then I. Repeat a second time → D first again.
- Same tie with ARB_RR_EN defined and last grant=D → I served first. On the next tie, D is served first.
- D write-back then refill: d_write, d_addr=0x3, d_wdata=X, then d_read with d_addr=0x7 → mem_write with mem_addr=0x3 and mem_wdata=X, ready, one IDLE cycle, then mem_read with mem_addr=0x7.
- d_read=d_write=1 → no grant, mem_* idle, arb_busy=0. Also mem_ready pulsed in IDLE → no client ready.
- proc_reset asserted mid-SERVE_I, between clock edges → mem_read=0, arb_busy=0 before the next edge. After release, a pending i_read is re-granted.
